// File: rtl/carry_save_resolver_if.sv
// carry_save_resolver_if
// Operand/result bus for the carry-save resolver.
//   inValid / inReady   : operand handshake (sumIn, carryIn)
//   outValid / outReady : result handshake (result, WIDTH+2 bits)
// The master modport is the side that supplies operands and consumes results;
// the slave modport is the resolver itself.
interface carry_save_resolver_if #(
  parameter int WIDTH = 32
) ();
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] sumIn;
  logic [WIDTH-1:0] carryIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH+1:0] result;

  modport master (
    output inValid, sumIn, carryIn, outReady,
    input  inReady, outValid, result
  );

  modport slave (
    input  inValid, sumIn, carryIn, outReady,
    output inReady, outValid, result
  );
endinterface

// File: rtl/carry_save_resolver.sv
// carry_save_resolver
// Turns a carry-save pair (sum vector plus carry vector, where carry bit i
// weighs 2^(i+1)) into a plain binary value, resolving CHUNK bits per clock so
// the carry chain stays short. The result is sumIn + 2*carryIn at full
// WIDTH+2 precision.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : carry_save_resolver_if.slave, operand and result handshakes
// Timing: an operand accepted at edge E produces outValid after edge E+N,
// with N = WIDTH/CHUNK.
module carry_save_resolver #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  carry_save_resolver_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // The chunked walk only makes sense when the chunks tile the word exactly.
  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : gBadChunk
      $error("carry_save_resolver: CHUNK must evenly divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT            stateQ;
  stateT            stateD;
  logic [WIDTH-1:0] aQ;
  logic [WIDTH-1:0] bQ;
  logic             topQ;
  logic [KW-1:0]    kQ;
  logic             cQ;
  logic [WIDTH+1:0] resultQ;

  logic             accept;
  logic             inReady;
  logic             outValid;
  logic             lastChunk;
  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum;

  // One chunk of the ripple add per cycle: pick the chunk addressed by the
  // counter and add it with the carry left over from the previous chunk.
  always_comb begin
    aChunk    = aQ[kQ*CHUNK +: CHUNK];
    bChunk    = bQ[kQ*CHUNK +: CHUNK];
    chunkSum  = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, cQ};
    lastChunk = (kQ == KW'(N - 1));
  end

  // State register for the IDLE -> BUSY -> DONE sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and handshake decode. Both ready and valid come straight from
  // the state, so a handoff in DONE can never be overlapped with a new accept.
  always_comb begin
    stateD   = stateQ;
    inReady  = 1'b0;
    outValid = 1'b0;
    accept   = 1'b0;
    case (stateQ)
      IDLE: begin
        inReady = 1'b1;
        if (bus.inValid) begin
          accept = 1'b1;
          stateD = BUSY;
        end
      end
      BUSY: begin
        if (lastChunk) begin
          stateD = DONE;
        end
      end
      DONE: begin
        outValid = 1'b1;
        if (bus.outReady) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Operand capture and chunk-by-chunk resolution. The carry vector is
  // pre-shifted left by one so both operands share bit weights; the bit that
  // falls off the top is kept aside and folded into the two extra result bits
  // together with the final chunk carry. The counter is left alone on the last
  // chunk so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aQ      <= '0;
      bQ      <= '0;
      topQ    <= 1'b0;
      kQ      <= '0;
      cQ      <= 1'b0;
      resultQ <= '0;
    end else if (accept) begin
      aQ   <= bus.sumIn;
      bQ   <= {bus.carryIn[WIDTH-2:0], 1'b0};
      topQ <= bus.carryIn[WIDTH-1];
      kQ   <= '0;
      cQ   <= 1'b0;
    end else if (stateQ == BUSY) begin
      resultQ[kQ*CHUNK +: CHUNK] <= chunkSum[CHUNK-1:0];
      cQ                         <= chunkSum[CHUNK];
      if (lastChunk) begin
        resultQ[WIDTH+1:WIDTH] <= {1'b0, topQ} + {1'b0, chunkSum[CHUNK]};
      end else begin
        kQ <= kQ + 1'b1;
      end
    end
  end

  assign bus.inReady  = inReady;
  assign bus.outValid = outValid;
  assign bus.result   = resultQ;

endmodule

// File: tb/tb_carry_save_resolver.sv
// tb_carry_save_resolver
// Directed bench for carry_save_resolver. The main instance (CHUNK=8) is
// tracked every cycle by a transaction-level model (value = sum + 2*carry,
// ready after N cycles, held until taken); two extra instances with CHUNK=32
// and CHUNK=1 cover the extreme chunk sizes.
module tb_carry_save_resolver;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  carry_save_resolver_if #(.WIDTH(WIDTH)) bus ();
  carry_save_resolver_if #(.WIDTH(WIDTH)) bus32 ();
  carry_save_resolver_if #(.WIDTH(WIDTH)) bus1 ();

  carry_save_resolver #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  carry_save_resolver #(.WIDTH(WIDTH), .CHUNK(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  carry_save_resolver #(.WIDTH(WIDTH), .CHUNK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Plain arithmetic meaning of a carry-save pair.
  function automatic logic [WIDTH+1:0] csaValue(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH+1:0] actual,
                             input logic [WIDTH+1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Transaction-level model of the main instance: an accepted pair becomes
  // available N cycles later and stays offered until the consumer takes it.
  logic [WIDTH+1:0] mExp;
  int               mLeft;
  bit               mDone;
  bit               mIdle;

  assign mIdle = !mDone && (mLeft == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mExp  <= '0;
      mLeft <= 0;
      mDone <= 1'b0;
    end else if (mIdle) begin
      if (bus.inValid === 1'b1) begin
        mExp  <= csaValue(bus.sumIn, bus.carryIn);
        mLeft <= N;
      end
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) mDone <= 1'b1;
    end else if (bus.outReady === 1'b1) begin
      mDone <= 1'b0;
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      checkOutput("modelInReady", {33'b0, bus.inReady}, {33'b0, mIdle});
      checkOutput("modelOutValid", {33'b0, bus.outValid}, {33'b0, mDone});
      if (mDone) checkOutput("modelResult", bus.result, mExp);
    end
  end

  // Present one pair to the main instance; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    @(negedge clk);
    bus.sumIn   = s;
    bus.carryIn = c;
    bus.inValid = 1'b1;
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
  endtask

  // Count edges until the main instance raises outValid (bounded).
  task automatic waitResult(output int lat);
    lat = 0;
    while (bus.outValid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Let the pending handoff edge pass and confirm the return to idle.
  task automatic finishHandoff(input string name);
    @(posedge clk);
    #1;
    checkOutput({name, "IdleReady"}, {33'b0, bus.inReady}, 34'd1);
    checkOutput({name, "IdleValid"}, {33'b0, bus.outValid}, 34'd0);
  endtask

  logic [WIDTH-1:0] sTab [8];
  logic [WIDTH-1:0] cTab [8];
  logic [WIDTH+1:0] gotResults [$];
  int               gotCycle [$];
  int               lat;
  int               lat32;
  int               lat1;
  int               guard;
  int               waitCycles;
  bit               accepted;

  initial begin
    sTab = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h0F0F0F0F,
             32'h13579BDF, 32'h7FFFFFFF, 32'hCAFEBABE, 32'h00000001};
    cTab = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hF0F0F0F0,
             32'h2468ACE0, 32'hFFFFFFFF, 32'h01234567, 32'hFFFFFFFF};

    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.sumIn    = '0;
    bus.carryIn  = '0;
    bus.outReady = 1'b1;
    bus32.inValid  = 1'b0;
    bus32.sumIn    = '0;
    bus32.carryIn  = '0;
    bus32.outReady = 1'b1;
    bus1.inValid   = 1'b0;
    bus1.sumIn     = '0;
    bus1.carryIn   = '0;
    bus1.outReady  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetInReady", {33'b0, bus.inReady}, 34'd1);
    checkOutput("resetOutValid", {33'b0, bus.outValid}, 34'd0);
    checkOutput("resetResult", bus.result, 34'd0);
    checkOutput("reset32InReady", {33'b0, bus32.inReady}, 34'd1);
    checkOutput("reset1InReady", {33'b0, bus1.inReady}, 34'd1);
    @(negedge clk);
    rst = 1'b0;

    // Ripple across every chunk boundary
    applyStimulus(32'h00FFFFFF, 32'h00000001);
    waitResult(lat);
    checkOutput("rippleLatency", 34'(lat), 34'd4);
    checkOutput("rippleResult", bus.result, 34'h001000001);
    finishHandoff("ripple");

    // Largest operands reach bit 33
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
    waitResult(lat);
    checkOutput("maxLatency", 34'(lat), 34'd4);
    checkOutput("maxResult", bus.result, 34'h2FFFFFFFD);
    finishHandoff("max");

    // Backpressure with stray operand pulses
    @(negedge clk);
    bus.outReady = 1'b0;
    applyStimulus(32'h12345678, 32'h0000000F);
    waitResult(lat);
    checkOutput("stallLatency", 34'(lat), 34'd4);
    for (int i = 0; i < 5; i++) begin
      bus.inValid = (i % 2 == 0);
      bus.sumIn   = 32'hFFFFFFFF;
      bus.carryIn = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      checkOutput("stallResult", bus.result, 34'h012345696);
      checkOutput("stallOutValid", {33'b0, bus.outValid}, 34'd1);
      checkOutput("stallInReady", {33'b0, bus.inReady}, 34'd0);
    end
    bus.inValid  = 1'b1;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
    checkOutput("handoffInReady", {33'b0, bus.inReady}, 34'd1);
    checkOutput("handoffOutValid", {33'b0, bus.outValid}, 34'd0);

    // Reset two cycles into BUSY
    applyStimulus(32'hDEADBEEF, 32'h12345678);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abortOutValid", {33'b0, bus.outValid}, 34'd0);
    checkOutput("abortResult", bus.result, 34'd0);
    checkOutput("abortInReady", {33'b0, bus.inReady}, 34'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h00000001, 32'h00000001);
    waitResult(lat);
    checkOutput("afterAbortLatency", 34'(lat), 34'd4);
    checkOutput("afterAbortResult", bus.result, 34'h3);
    finishHandoff("afterAbort");

    // Back-to-back stream with inValid held high
    bus.outReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          bus.sumIn   = sTab[i];
          bus.carryIn = cTab[i];
          bus.inValid = 1'b1;
          guard    = 0;
          accepted = 1'b0;
          while (!accepted && guard < 50) begin
            @(negedge clk);
            accepted = mIdle;
            @(posedge clk);
            #1;
            guard++;
          end
        end
        bus.inValid = 1'b0;
      end
      begin
        waitCycles = 0;
        while (gotResults.size() < 8 && waitCycles < 400) begin
          @(negedge clk);
          waitCycles++;
          if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
            gotResults.push_back(bus.result);
            gotCycle.push_back(cycle);
          end
        end
      end
    join
    checkOutput("streamCount", 34'(gotResults.size()), 34'd8);
    for (int i = 0; i < gotResults.size(); i++) begin
      checkOutput("streamResult", gotResults[i], csaValue(sTab[i], cTab[i]));
      if (i > 0) checkOutput("streamSpacing", 34'(gotCycle[i] - gotCycle[i-1]), 34'd6);
    end
    repeat (3) @(posedge clk);

    // Chunk-size extremes
    @(negedge clk);
    bus32.sumIn   = 32'hFFFFFFFF;
    bus32.carryIn = 32'h00000000;
    bus32.inValid = 1'b1;
    bus1.sumIn    = 32'hFFFFFFFF;
    bus1.carryIn  = 32'h00000000;
    bus1.inValid  = 1'b1;
    @(posedge clk);
    #1;
    bus32.inValid = 1'b0;
    bus1.inValid  = 1'b0;
    fork
      begin
        lat32 = 0;
        while (bus32.outValid !== 1'b1 && lat32 < 100) begin
          @(posedge clk);
          #1;
          lat32++;
        end
        checkOutput("chunk32Latency", 34'(lat32), 34'd1);
        checkOutput("chunk32Result", bus32.result, 34'h0FFFFFFFF);
      end
      begin
        lat1 = 0;
        while (bus1.outValid !== 1'b1 && lat1 < 100) begin
          @(posedge clk);
          #1;
          lat1++;
        end
        checkOutput("chunk1Latency", 34'(lat1), 34'd32);
        checkOutput("chunk1Result", bus1.result, 34'h0FFFFFFFF);
      end
    join
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_save_resolver.md
# carry_save_resolver

Sequential carry-propagate stage that converts a carry-save pair (sum vector, carry vector as produced by the carry-save adder array) into a single conventional binary result. It sits at the output of the multiply/divide datapath's redundant accumulation tree and resolves CHUNK bits per cycle, trading latency for a short carry chain. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- WIDTH, 32, bit width of the sum and carry input vectors.
- CHUNK, 8, bits resolved per cycle; must divide WIDTH evenly (elaboration error otherwise). N = WIDTH/CHUNK.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inValid  input  1  sumIn/carryIn hold a valid operand pair.
- inReady  output  1  block can accept an operand pair this cycle.
- sumIn  input  WIDTH  sum vector; bit i has weight 2^i.
- carryIn  input  WIDTH  carry vector; bit i has weight 2^(i+1).
- outValid  output  1  result holds a completed value.
- outReady  input  1  consumer accepts result this cycle.
- result  output  WIDTH+2  sumIn + 2*carryIn, full precision, never truncated.

## Operation
- States: IDLE, BUSY, DONE. Reset state IDLE.
- inReady = 1 only in IDLE (decoded from state; high during and after reset). outValid = 1 only in DONE.
- IDLE: on inValid & inReady, latch A = sumIn, B = {carryIn[WIDTH-2:0], 1'b0}, top = carryIn[WIDTH-1]; clear chunk counter k and carry flag c; go BUSY.
- BUSY, per cycle: {c, result[k*CHUNK +: CHUNK]} <= A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + c; k <= k+1.
- On the cycle k = N-1, additionally result[WIDTH+1:WIDTH] <= top + carry-out of that chunk; go DONE.
- DONE: result and outValid held stable until outReady = 1; then go IDLE. No new operand accepted in the same cycle as the handoff.
- inValid while not in IDLE is ignored; sumIn/carryIn changes after acceptance have no effect.
- Arithmetic: unsigned. Maximum value 3*(2^WIDTH - 1) fits in WIDTH+2 bits; result bits above those written in the current operation hold their previous values until written (only DONE contents are architecturally defined).
- Counter k is ceil(log2(N)) bits, minimum 1; no wrap-around occurs because BUSY exits at k = N-1.

## Timing
- Reset (async assert, sync-safe release): state IDLE, result = 0, k = 0, c = 0, outValid = 0, inReady = 1.
- Reset asserted in BUSY or DONE: operation abandoned, result discarded, all outputs to reset values immediately.
- Latency: operand accepted at edge E; outValid high after edge E+N (N BUSY cycles). Default parameters: 4 cycles.
- Throughput: one result per N+2 cycles with outReady held high (accept, N BUSY, DONE handoff).
- Backpressure: outReady low in DONE stalls indefinitely; result bits must not change while outValid = 1.
- outReady while outValid = 0 has no effect.

## Test plan
- Cross-chunk ripple: sumIn=0x00FFFFFF, carryIn=0x00000001 -> result=0x001000001 after exactly 4 BUSY cycles; outValid rises at E+4.
- Maximum operands: sumIn=0xFFFFFFFF, carryIn=0xFFFFFFFF -> result=0x2FFFFFFFD (bit 33 set, full WIDTH+2 precision).
- Backpressure: complete sumIn=0x12345678, carryIn=0x0000000F (result 0x123456 96) with outReady low 5 cycles -> result stable at 0x012345696, inReady=0 throughout, extra inValid pulses ignored; handoff on outReady, IDLE next cycle.
- Reset mid-operation: assert rst two cycles into BUSY -> outValid=0, result=0, inReady=1 immediately; next operand sumIn=0x1, carryIn=0x1 -> result=0x3.
- Back-to-back: inValid held high with 8 random pairs, outReady high -> each result equals sumIn + 2*carryIn, one result every 6 cycles, none dropped or duplicated.
- Parameter sweep: CHUNK=32 (N=1) and CHUNK=1 (N=32) with sumIn=0xFFFFFFFF, carryIn=0x00000000 -> result=0x0FFFFFFFF at latency 1 and 32 respectively.
